// File: rtl/pause_dim_ctrl.sv
// rtl/pause_dim_ctrl.sv - merged pause source with idle-time video dimming
// Combines button/request/OSD pause into pause_cpu and fades RGB in shift steps after idle time.
module pause_dim_ctrl #(
  parameter int RW         = 4,
  parameter int GW         = 4,
  parameter int BW         = 4,
  parameter int REQ_N      = 2,
  parameter int TICK_DIV   = 48000,
  parameter int DIM_TICKS  = 10000,
  parameter int FADE_TICKS = 250,
  parameter int MAX_SHIFT  = 1
) (
  input  logic                               clk_sys,
  input  logic                               reset_n,
  input  logic                               user_button,
  input  logic [REQ_N-1:0]                   pause_request,
  input  logic                               OSD_STATUS,
  input  logic [1:0]                         options,
  input  logic [RW+GW+BW-1:0]                rgb_in,
  output logic [RW+GW+BW-1:0]                rgb_out,
  output logic                               pause_cpu,
  output logic [$clog2(MAX_SHIFT+1)-1:0]     dim_level
);

  localparam int LW   = $clog2(MAX_SHIFT + 1);
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IMAX = (DIM_TICKS > FADE_TICKS) ? DIM_TICKS : FADE_TICKS;
  localparam int IW   = $clog2(IMAX + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSED  = 2'd1,
    DIMMING = 2'd2,
    DIMMED  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d, level_inc;
  logic [TW-1:0] tick_cnt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic          btn_q, user_pause;
  logic          btn_rise, pause_src;
  logic          cnt_clr, cnt_hold, tick, step;

  assign btn_rise  = user_button & ~btn_q;
  assign pause_src = user_pause | (|pause_request) | (options[0] & OSD_STATUS);

  // Counting stops as soon as the pause source drops so an unpause always beats a tick.
  assign cnt_clr   = ~(pause_cpu & options[1] & pause_src);
  assign cnt_hold  = (state_q == DIMMED);
  assign tick      = ~cnt_clr & ~cnt_hold & (tick_cnt == TW'(TICK_DIV - 1));
  assign idle_nxt  = idle_cnt + 1'b1;
  assign step      = tick & (((state_q == PAUSED)  && (idle_nxt == IW'(DIM_TICKS))) ||
                             ((state_q == DIMMING) && (idle_nxt == IW'(FADE_TICKS))));
  assign level_inc = level_q + 1'b1;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      btn_q      <= 1'b0;
      user_pause <= 1'b0;
      pause_cpu  <= 1'b0;
    end else begin
      btn_q      <= user_button;
      user_pause <= user_pause ^ btn_rise;
      pause_cpu  <= pause_src;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || cnt_clr) begin
      tick_cnt <= '0;
      idle_cnt <= '0;
    end else if (!cnt_hold) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (step)
        idle_cnt <= '0;
      else if (tick)
        idle_cnt <= idle_nxt;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= RUN;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (!pause_src) begin
      state_d = RUN;
      level_d = '0;
    end else if (state_q == RUN) begin
      if (pause_cpu)
        state_d = PAUSED;
    end else if (!options[1]) begin
      state_d = PAUSED;
      level_d = '0;
    end else if (step) begin
      level_d = level_inc;
      state_d = (level_inc == LW'(MAX_SHIFT)) ? DIMMED : DIMMING;
    end
  end

  // Each channel is shifted on its own slice so no bits leak between colours.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= {rgb_in[RW+GW+BW-1 -: RW] >> level_q,
                  rgb_in[GW+BW-1 -: GW]    >> level_q,
                  rgb_in[BW-1:0]           >> level_q};
    end
  end

  assign dim_level = level_q;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// tb/tb_pause_dim_ctrl.sv - directed self-checking bench for pause_dim_ctrl
// Small timer parameters so pause, fade and unpause sequences fit in a few dozen cycles.
module tb_pause_dim_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        user_button;
  logic [1:0]  pause_request;
  logic        OSD_STATUS;
  logic [1:0]  options;
  logic [11:0] rgb_in;
  logic [11:0] rgb_out;
  logic        pause_cpu;
  logic [1:0]  dim_level;

  int checks = 0;
  int errors = 0;

  pause_dim_ctrl #(
    .RW(4), .GW(4), .BW(4), .REQ_N(2),
    .TICK_DIV(4), .DIM_TICKS(3), .FADE_TICKS(2), .MAX_SHIFT(2)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .user_button   (user_button),
    .pause_request (pause_request),
    .OSD_STATUS    (OSD_STATUS),
    .options       (options),
    .rgb_in        (rgb_in),
    .rgb_out       (rgb_out),
    .pause_cpu     (pause_cpu),
    .dim_level     (dim_level)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      user_button   = i[0];
      pause_request = 2'(i + 1);
      OSD_STATUS    = ~i[0];
      step(1);
    end
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b want 0", pause_cpu); end
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL reset_dim: got %0d want 0", dim_level); end
    checks++;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
    user_button = 1'b0; pause_request = 2'b00; OSD_STATUS = 1'b0;
    reset_n = 1'b1;
    step(1);
    checks++;
    if (rgb_out !== 12'hF84) begin errors++; $display("FAIL reset_rgb_after: got %h want F84", rgb_out); end
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL reset_pause_after: got %b want 0", pause_cpu); end
  endtask

  task automatic test_button;
    user_button = 1'b1;
    step(1);
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL btn_lat1: got %b want 0", pause_cpu); end
    step(1);
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL btn_lat2: got %b want 1", pause_cpu); end
    for (int i = 0; i < 18; i++) begin
      step(1);
      checks++;
      if (pause_cpu !== 1'b1) begin errors++; $display("FAIL btn_held cyc %0d: got %b want 1", i, pause_cpu); end
    end
    user_button = 1'b0;
    step(1);
    user_button = 1'b1;
    step(1);
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL btn_off_lat1: got %b want 1", pause_cpu); end
    step(1);
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL btn_off_lat2: got %b want 0", pause_cpu); end
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL btn_off_dim: got %0d want 0", dim_level); end
    user_button = 1'b0;
    step(2);
  endtask

  task automatic test_fade;
    pause_request = 2'b01;
    step(1);
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL fade_pause: got %b want 1", pause_cpu); end
    step(11);
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL fade_pre1: got %0d want 0", dim_level); end
    step(1);
    checks++;
    if (dim_level !== 2'd1) begin errors++; $display("FAIL fade_lvl1: got %0d want 1", dim_level); end
    step(1);
    checks++;
    if (rgb_out !== 12'h742) begin errors++; $display("FAIL fade_rgb1: got %h want 742", rgb_out); end
    step(6);
    checks++;
    if (dim_level !== 2'd1) begin errors++; $display("FAIL fade_pre2: got %0d want 1", dim_level); end
    step(1);
    checks++;
    if (dim_level !== 2'd2) begin errors++; $display("FAIL fade_lvl2: got %0d want 2", dim_level); end
    step(1);
    checks++;
    if (rgb_out !== 12'h321) begin errors++; $display("FAIL fade_rgb2: got %h want 321", rgb_out); end
    step(10);
    checks++;
    if (dim_level !== 2'd2 || rgb_out !== 12'h321) begin
      errors++; $display("FAIL fade_hold: got lvl %0d rgb %h want 2 321", dim_level, rgb_out);
    end
  endtask

  task automatic test_unpause;
    pause_request = 2'b00;
    step(1);
    checks++;
    if (pause_cpu !== 1'b0 || dim_level !== 2'd0) begin
      errors++; $display("FAIL unp_dimmed: got pause %b lvl %0d want 0 0", pause_cpu, dim_level);
    end
    step(1);
    checks++;
    if (rgb_out !== 12'hF84) begin errors++; $display("FAIL unp_dimmed_rgb: got %h want F84", rgb_out); end
    pause_request = 2'b01;
    step(13);
    checks++;
    if (dim_level !== 2'd1) begin errors++; $display("FAIL unp_setup: got %0d want 1", dim_level); end
    pause_request = 2'b00;
    step(1);
    checks++;
    if (pause_cpu !== 1'b0 || dim_level !== 2'd0) begin
      errors++; $display("FAIL unp_mid: got pause %b lvl %0d want 0 0", pause_cpu, dim_level);
    end
    step(1);
    checks++;
    if (rgb_out !== 12'hF84) begin errors++; $display("FAIL unp_mid_rgb: got %h want F84", rgb_out); end
    pause_request = 2'b01;
    step(12);
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL repause_wait: got %0d want 0", dim_level); end
    step(1);
    checks++;
    if (dim_level !== 2'd1) begin errors++; $display("FAIL repause_lvl1: got %0d want 1", dim_level); end
    pause_request = 2'b00;
    step(2);
  endtask

  task automatic test_osd;
    options = 2'b10; OSD_STATUS = 1'b1;
    step(3);
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL osd_gated: got %b want 0", pause_cpu); end
    options = 2'b11;
    step(1);
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL osd_pause: got %b want 1", pause_cpu); end
    step(20);
    checks++;
    if (dim_level !== 2'd2) begin errors++; $display("FAIL osd_dimmed: got %0d want 2", dim_level); end
    options = 2'b01;
    step(1);
    checks++;
    if (dim_level !== 2'd0 || pause_cpu !== 1'b1) begin
      errors++; $display("FAIL osd_dim_off: got lvl %0d pause %b want 0 1", dim_level, pause_cpu);
    end
    step(15);
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL osd_dim_off_hold: got %0d want 0", dim_level); end
    options = 2'b11; OSD_STATUS = 1'b0;
    step(1);
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL osd_close: got %b want 0", pause_cpu); end
    step(2);
  endtask

  task automatic test_overlap;
    user_button = 1'b1;
    step(1);
    user_button = 1'b0;
    step(1);
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL ovl_pause: got %b want 1", pause_cpu); end
    step(20);
    checks++;
    if (dim_level !== 2'd2) begin errors++; $display("FAIL ovl_dimmed: got %0d want 2", dim_level); end
    pause_request = 2'b10;
    step(3);
    pause_request = 2'b00;
    step(1);
    checks++;
    if (pause_cpu !== 1'b1 || dim_level !== 2'd2) begin
      errors++; $display("FAIL ovl_drop: got pause %b lvl %0d want 1 2", pause_cpu, dim_level);
    end
    step(5);
    checks++;
    if (pause_cpu !== 1'b1 || dim_level !== 2'd2 || rgb_out !== 12'h321) begin
      errors++; $display("FAIL ovl_hold: got pause %b lvl %0d rgb %h want 1 2 321", pause_cpu, dim_level, rgb_out);
    end
    user_button = 1'b1;
    step(1);
    user_button = 1'b0;
    step(1);
    checks++;
    if (pause_cpu !== 1'b0 || dim_level !== 2'd0) begin
      errors++; $display("FAIL ovl_release: got pause %b lvl %0d want 0 0", pause_cpu, dim_level);
    end
    step(1);
    checks++;
    if (rgb_out !== 12'hF84) begin errors++; $display("FAIL ovl_release_rgb: got %h want F84", rgb_out); end
  endtask

  initial begin
    reset_n = 1'b0; user_button = 1'b0; pause_request = 2'b00;
    OSD_STATUS = 1'b0; options = 2'b11; rgb_in = 12'hF84;
    step(1);
    test_reset;
    test_button;
    test_fade;
    test_unpause;
    test_osd;
    test_overlap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pause_dim_ctrl.md
Name: pause_dim_ctrl

Overview:
- Parametrised successor to the core-level pause block.
- Merges several pause sources into one registered `pause_cpu`: user button toggle, N external requests (hiscore, loaders), and OSD-open.
- After a programmable idle time in pause, fades the video to a configurable depth in steps. RGB channel widths are parameters.
- Sits between the core's RGB output and the `arcade_video`/`screen_rotate` chain; runs in `clk_sys`.

Parameters:
- RW, 4, red channel width (bits)
- GW, 4, green channel width
- BW, 4, blue channel width
- REQ_N, 2, number of external pause request inputs (≥1)
- TICK_DIV, 48000, `clk_sys` cycles per timer tick (1 ms at 48 MHz)
- DIM_TICKS, 10000, ticks in pause before the first dim step
- FADE_TICKS, 250, ticks between successive dim steps
- MAX_SHIFT, 1, final dim depth as a right-shift count (1..min(RW,GW,BW))

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- user_button  in  1  level; each rising edge toggles user pause
- pause_request  in  REQ_N  level requests; any bit high forces pause
- OSD_STATUS  in  1  OSD open
- options  in  2  [0]=pause when OSD open, [1]=dim enable
- rgb_in  in  RW+GW+BW  {R,G,B}, R in MSBs
- rgb_out  out  RW+GW+BW  possibly dimmed pixel, registered
- pause_cpu  out  1  registered pause to the core
- dim_level  out  clog2(MAX_SHIFT+1)  current shift count

Behaviour:
- Reset (`reset_n` low at a clock edge) clears everything:
  - user_pause=0, button edge register=0, all counters=0, state=RUN.
  - Outputs: `pause_cpu`=0, `dim_level`=0, `rgb_out`=0.
- Edge detect: `btn_q <= user_button`. Rise = `user_button & ~btn_q`. Rise toggles `user_pause`. Button held high gives exactly one toggle.
- `pause_src` = `user_pause | (|pause_request) | (options[0] & OSD_STATUS)`.
- `pause_cpu` <= `pause_src`. Latency is 1 cycle from request or OSD change; 2 cycles from button change.
- Timer:
  - `tick_cnt` counts 0..TICK_DIV-1 while `pause_cpu`=1 and `options[1]`=1. A tick pulses on wrap.
  - `idle_cnt` counts ticks.
  - Both are cleared in any cycle with `pause_cpu`=0 or `options[1]`=0.
- States:
  - RUN: `pause_cpu`=0, level 0.
    - → PAUSED when `pause_cpu`=1.
  - PAUSED: waiting, level 0.
    - → DIMMING when `idle_cnt` reaches DIM_TICKS. In the same cycle, level=1 and `idle_cnt` is cleared.
  - DIMMING: on each FADE_TICKS ticks, level+1 and `idle_cnt` is cleared.
    - → DIMMED when level reaches MAX_SHIFT.
    - If MAX_SHIFT=1, go PAUSED→DIMMED directly.
  - DIMMED: level holds at MAX_SHIFT; counters hold.
  - From any state:
    - `pause_cpu`=0 → RUN, level=0 in the same cycle.
    - `options[1]`=0 → PAUSED (if paused), level=0, counters cleared.
- Simultaneous events:
  - Unpause beats a tick or step in the same cycle.
  - A request dropping while `user_pause`=1 keeps the pause and keeps the state and level.
- Output path:
  - `rgb_out` <= each channel logically shifted right by level.
  - 1-cycle latency, no saturation or rounding.
  - Channels are shifted independently; no bits carry between channels.
- Widths:
  - `tick_cnt` = clog2(TICK_DIV).
  - `idle_cnt` = clog2(max(DIM_TICKS,FADE_TICKS)+1).
  - No overflow is possible because counts are cleared at their limits.

Test Plan:
All scenarios use RW=GW=BW=4, REQ_N=2, TICK_DIV=4, DIM_TICKS=3, FADE_TICKS=2, MAX_SHIFT=2, options=2'b11, `rgb_in`=12'hF84.

1. Reset
   - Stimulus: `reset_n` low for 2 cycles, inputs toggling.
   - Required: `pause_cpu`=0, `dim_level`=0, `rgb_out`=0. One cycle after release, `rgb_out`=F84.
2. Button toggle
   - Stimulus: `user_button` held high 20 cycles.
   - Required: `pause_cpu`=1 two cycles after the rise and stays 1. A second rise clears it two cycles later.
3. Fade
   - Stimulus: pause via `pause_request`=2'b01.
   - Required:
     - `pause_cpu` rises.
     - 12 cycles later `dim_level`=1, `rgb_out`=742 one cycle after that.
     - 8 cycles after that `dim_level`=2, `rgb_out`=321; it holds.
4. Unpause mid-fade
   - Stimulus: request drops while `dim_level`=1.
   - Required: the cycle `pause_cpu` falls, `dim_level`=0. Next cycle `rgb_out`=F84. A re-pause restarts the full 12-cycle wait.
5. OSD gating
   - Stimulus: `OSD_STATUS`=1 with options[0]=0.
   - Required: `pause_cpu` stays 0.
   - Stimulus: options[0]=1.
   - Required: `pause_cpu`=1 next cycle.
   - Stimulus: options[1]=0 while DIMMED.
   - Required: `dim_level`=0, `pause_cpu` stays 1.
6. Overlapping sources
   - Stimulus: user pause on, then request bit1 pulses 1→0 during DIMMED.
   - Required: `pause_cpu` stays 1, `dim_level` stays 2.
